// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the direct-mapped data cache.
package dcache_pkg;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned OFFSET_BITS = 2;
  localparam int unsigned MEM_ADDR_W  = 6;
  localparam int unsigned BLOCK_W     = 32;
  localparam int unsigned BYTE_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FETCH     = 2'd2,
    ST_UPDATE    = 2'd3
  } state_e;

  function automatic logic [OFFSET_BITS-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_BITS-1:0];
  endfunction

  // Block address {tag, index}; index occupies the low index_bits.
  function automatic logic [MEM_ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] addr,
                                                       input int unsigned index_bits);
    logic [MEM_ADDR_W-1:0] blk;
    logic [MEM_ADDR_W-1:0] mask;
    blk  = addr[ADDR_W-1:OFFSET_BITS];
    mask = (MEM_ADDR_W'(1) << index_bits) - MEM_ADDR_W'(1);
    return blk & mask;
  endfunction

  function automatic logic [MEM_ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr,
                                                     input int unsigned index_bits);
    logic [MEM_ADDR_W-1:0] blk;
    blk = addr[ADDR_W-1:OFFSET_BITS];
    return blk >> index_bits;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage with a CPU byte-write port and a memory block-fill port.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 3,
  parameter int unsigned TAG_BITS   = 3
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [INDEX_BITS-1:0]  i_index,
  input  logic [OFFSET_BITS-1:0] i_offset,
  input  logic                   i_byte_we,
  input  logic [BYTE_W-1:0]      i_byte_data,
  input  logic                   i_fill_we,
  input  logic [TAG_BITS-1:0]    i_fill_tag,
  input  logic [BLOCK_W-1:0]     i_fill_data,
  output logic                   o_valid,
  output logic                   o_dirty,
  output logic [TAG_BITS-1:0]    o_tag,
  output logic [BLOCK_W-1:0]     o_block,
  output logic [BYTE_W-1:0]      o_byte
);

  localparam int unsigned NUM_BLOCKS = 2 ** INDEX_BITS;

  logic [NUM_BLOCKS-1:0] r_valid;
  logic [NUM_BLOCKS-1:0] r_dirty;
  logic [TAG_BITS-1:0]   r_tag  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    r_data [NUM_BLOCKS];
  logic [4:0]            w_bit_lo;

  assign w_bit_lo = {i_offset, 3'b000};

  // Status bits clear on reset; a fill always wins over a byte write.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_we) begin
      r_valid[i_index] <= 1'b1;
      r_dirty[i_index] <= 1'b0;
    end else if (i_byte_we) begin
      r_dirty[i_index] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (i_fill_we) begin
        r_tag[i_index]  <= i_fill_tag;
        r_data[i_index] <= i_fill_data;
      end else if (i_byte_we) begin
        r_data[i_index][w_bit_lo +: BYTE_W] <= i_byte_data;
      end
    end
  end

  assign o_valid = r_valid[i_index];
  assign o_dirty = r_dirty[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_block = r_data[i_index];
  assign o_byte  = o_block[w_bit_lo +: BYTE_W];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate cache controller: hit path, miss FSM, memory handshake.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_W-1:0]     ADDRESS,
  input  logic [BYTE_W-1:0]     WRITEDATA,
  output logic [BYTE_W-1:0]     READDATA,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  localparam int unsigned TAG_BITS = MEM_ADDR_W - INDEX_BITS;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [INDEX_BITS-1:0]  w_index;
  logic [TAG_BITS-1:0]    w_tag;
  logic [OFFSET_BITS-1:0] w_offset;
  logic                   w_valid;
  logic                   w_dirty;
  logic [TAG_BITS-1:0]    w_line_tag;
  logic [BLOCK_W-1:0]     w_block;
  logic                   w_req;
  logic                   w_hit;
  logic                   w_byte_we;
  logic                   w_fill_we;

  assign w_index  = INDEX_BITS'(addr_index(ADDRESS, INDEX_BITS));
  assign w_tag    = TAG_BITS'(addr_tag(ADDRESS, INDEX_BITS));
  assign w_offset = addr_offset(ADDRESS);

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .CLK         (CLK),
    .RESET       (RESET),
    .i_index     (w_index),
    .i_offset    (w_offset),
    .i_byte_we   (w_byte_we),
    .i_byte_data (WRITEDATA),
    .i_fill_we   (w_fill_we),
    .i_fill_tag  (w_tag),
    .i_fill_data (MEM_READDATA),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty),
    .o_tag       (w_line_tag),
    .o_block     (w_block),
    .o_byte      (READDATA)
  );

  // A simultaneous READ+WRITE falls through as a store since WRITE alone gates the byte write.
  assign w_req         = READ | WRITE;
  assign w_hit         = w_valid & (w_line_tag == w_tag);
  assign BUSYWAIT      = w_req & ~((r_state == ST_IDLE) & w_hit);
  assign w_byte_we     = (r_state == ST_IDLE) & w_hit & WRITE;
  assign MEM_WRITEDATA = w_block;

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    MEM_READ    = 1'b0;
    MEM_WRITE   = 1'b0;
    MEM_ADDRESS = {w_tag, w_index};
    w_fill_we   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req && !w_hit) begin
          w_state_nxt = (w_valid && w_dirty) ? ST_WRITEBACK : ST_FETCH;
        end
      end
      ST_WRITEBACK: begin
        MEM_WRITE   = 1'b1;
        MEM_ADDRESS = {w_line_tag, w_index};
        if (!MEM_BUSYWAIT) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        MEM_READ = 1'b1;
        if (!MEM_BUSYWAIT) w_state_nxt = ST_UPDATE;
      end
      ST_UPDATE: begin
        w_fill_we   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: byte-level memory model plus per-cycle protocol monitor.
module tb_dcache_controller;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  always #5 CLK = ~CLK;

  dcache_controller #(.INDEX_BITS(3)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  // Backing memory: busy for mem_extra cycles per access, then completes.
  logic [31:0] mem [64];
  int          mem_cnt;
  int          mem_extra;
  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mem_cnt < mem_extra);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  // Architectural model: what every byte address must read as, plus line residency.
  logic [7:0]  arch [256];
  logic        m_valid [8];
  logic        m_dirty [8];
  logic [2:0]  m_tag [8];

  int          n_chk;
  int          n_pass;
  int          wb_count;
  int          fetch_count;
  logic [5:0]  last_wb_addr;
  logic [31:0] last_wb_data;
  logic [5:0]  last_fetch_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] arch_block(input logic [5:0] blk);
    logic [7:0] base;
    base = {blk, 2'b00};
    return {arch[base + 8'd3], arch[base + 8'd2], arch[base + 8'd1], arch[base]};
  endfunction

  // Dirty lines are lost on reset, so the visible image falls back to memory.
  task automatic model_reset();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] ba;
      ba = 8'(a);
      arch[a] = mem[ba[7:2]][{ba[1:0], 3'b000} +: 8];
    end
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 3'd0;
    end
  endtask

  task automatic mem_proc();
    forever begin
      @(posedge CLK);
      if ((MEM_READ | MEM_WRITE) && MEM_BUSYWAIT) mem_cnt <= mem_cnt + 1;
      else mem_cnt <= 0;
      if (MEM_WRITE && !MEM_BUSYWAIT) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
    end
  endtask

  task automatic monitor();
    logic prev_rd;
    logic prev_mb;
    prev_rd = 1'b0;
    prev_mb = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      check("mem_exclusive", 32'(MEM_READ & MEM_WRITE), 32'd0);
      if (!READ && !WRITE) check("busy_no_req", 32'(BUSYWAIT), 32'd0);
      if (READ && !WRITE && !BUSYWAIT && !RESET) check("readdata", 32'(READDATA), 32'(arch[ADDRESS]));
      if (prev_rd && prev_mb && !RESET) check("fetch_hold", 32'(MEM_READ), 32'd1);
      if (MEM_WRITE && !MEM_BUSYWAIT) begin
        wb_count++;
        last_wb_addr = MEM_ADDRESS;
        last_wb_data = MEM_WRITEDATA;
        check("wb_block", MEM_WRITEDATA, arch_block(MEM_ADDRESS));
        check("wb_index", 32'(MEM_ADDRESS[2:0]), 32'(ADDRESS[4:2]));
      end
      if (MEM_READ && !MEM_BUSYWAIT) begin
        fetch_count++;
        last_fetch_addr = MEM_ADDRESS;
        check("fetch_addr", 32'(MEM_ADDRESS), 32'(ADDRESS[7:2]));
      end
      prev_rd = MEM_READ;
      prev_mb = MEM_BUSYWAIT;
    end
  endtask

  // One CPU access: hold until BUSYWAIT falls, count stall cycles, compare with the model.
  task automatic do_req(input logic rd, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wdata, output int stall, output logic [7:0] rdata);
    logic [2:0] idx;
    logic [2:0] tg;
    logic       hit;
    int         exp_stall;
    idx = addr[4:2];
    tg  = addr[7:5];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (hit) exp_stall = 0;
    else if (m_valid[idx] && m_dirty[idx]) exp_stall = 4 + 2 * mem_extra;
    else exp_stall = 3 + mem_extra;
    @(negedge CLK);
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wdata;
    stall = 0;
    #1;
    while (BUSYWAIT && stall < 200) begin
      stall++;
      @(negedge CLK);
      #1;
    end
    check("stall_cycles", 32'(stall), 32'(exp_stall));
    rdata = READDATA;
    @(posedge CLK);
    if (wr) arch[addr] = wdata;
    m_dirty[idx] = wr | (hit & m_dirty[idx]);
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
    @(negedge CLK);
    READ = 1'b0; WRITE = 1'b0;
  endtask

  int         st;
  logic [7:0] rd;
  int         wb0;
  int         fe0;
  int         waited;

  initial begin
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'd0; WRITEDATA = 8'd0;
    n_chk = 0; n_pass = 0; wb_count = 0; fetch_count = 0;
    mem_cnt = 0; mem_extra = 0;
    last_wb_addr = '0; last_wb_data = '0; last_fetch_addr = '0;
    for (int i = 0; i < 64; i++) begin
      logic [5:0] w;
      w = 6'(i);
      mem[i] = {w, 2'b11, w, 2'b10, w, 2'b01, w, 2'b00};
    end
    mem[1] = 32'hDDCC_BBAA;
    model_reset();
    fork
      mem_proc();
    join_none
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("reset_busywait", 32'(BUSYWAIT), 32'd0);
    check("reset_mem_read", 32'(MEM_READ), 32'd0);
    check("reset_mem_write", 32'(MEM_WRITE), 32'd0);
    fork
      monitor();
    join_none

    // Clean read miss.
    wb0 = wb_count; fe0 = fetch_count;
    do_req(1'b1, 1'b0, 8'h04, 8'h00, st, rd);
    check("clean_miss_stall", 32'(st), 32'd3);
    check("clean_miss_data", 32'(rd), 32'hAA);
    check("clean_miss_fetch_addr", 32'(last_fetch_addr), 32'h01);
    check("clean_miss_fetches", 32'(fetch_count - fe0), 32'd1);
    check("clean_miss_no_wb", 32'(wb_count - wb0), 32'd0);

    // Write hit then read back.
    do_req(1'b0, 1'b1, 8'h05, 8'h5A, st, rd);
    check("write_hit_stall", 32'(st), 32'd0);
    do_req(1'b1, 1'b0, 8'h05, 8'h00, st, rd);
    check("read_after_write", 32'(rd), 32'h5A);

    // Dirty miss on the same index.
    wb0 = wb_count;
    do_req(1'b1, 1'b0, 8'h25, 8'h00, st, rd);
    check("dirty_miss_stall", 32'(st), 32'd4);
    check("dirty_miss_wbs", 32'(wb_count - wb0), 32'd1);
    check("dirty_wb_addr", 32'(last_wb_addr), 32'h01);
    check("dirty_wb_data", last_wb_data, 32'hDDCC_5AAA);
    check("dirty_fetch_addr", 32'(last_fetch_addr), 32'h09);
    check("dirty_miss_data", 32'(rd), 32'h25);

    // Write miss allocates, then the store lands.
    do_req(1'b0, 1'b1, 8'h44, 8'h11, st, rd);
    check("write_miss_stall", 32'(st), 32'd3);
    do_req(1'b1, 1'b0, 8'h44, 8'h00, st, rd);
    check("write_miss_readback", 32'(rd), 32'h11);

    // Slow memory holds MEM_BUSYWAIT for 5 cycles.
    mem_extra = 5;
    do_req(1'b1, 1'b0, 8'h48, 8'h00, st, rd);
    check("slow_fetch_stall", 32'(st), 32'd8);
    check("slow_fetch_data", 32'(rd), 32'h48);
    mem_extra = 0;

    // READ and WRITE together behave as a store.
    do_req(1'b1, 1'b1, 8'h49, 8'h77, st, rd);
    check("rw_both_stall", 32'(st), 32'd0);
    do_req(1'b1, 1'b0, 8'h49, 8'h00, st, rd);
    check("rw_both_readback", 32'(rd), 32'h77);

    // Evict the dirty write-allocated line.
    do_req(1'b1, 1'b0, 8'h04, 8'h00, st, rd);
    check("evict_stall", 32'(st), 32'd4);
    check("evict_wb_addr", 32'(last_wb_addr), 32'h11);
    check("evict_wb_data", last_wb_data, 32'h4746_4511);
    check("evict_data", 32'(rd), 32'hAA);
    do_req(1'b1, 1'b0, 8'h05, 8'h00, st, rd);
    check("persisted_store", 32'(rd), 32'h5A);

    // Reset in the middle of a fetch.
    mem_extra = 3;
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 8'h0C;
    waited = 0;
    #1;
    while (!MEM_READ && waited < 20) begin
      waited++;
      @(negedge CLK);
      #1;
    end
    check("fetch_started", 32'(MEM_READ), 32'd1);
    @(negedge CLK);
    RESET = 1'b1; READ = 1'b0;
    @(posedge CLK);
    #1;
    check("reset_mid_mem_read", 32'(MEM_READ), 32'd0);
    check("reset_mid_busywait", 32'(BUSYWAIT), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    mem_extra = 0;
    model_reset();
    do_req(1'b1, 1'b0, 8'h0C, 8'h00, st, rd);
    check("post_reset_stall", 32'(st), 32'd3);
    check("post_reset_data", 32'(rd), 32'h0C);
    do_req(1'b1, 1'b0, 8'h49, 8'h00, st, rd);
    check("discarded_dirty_stall", 32'(st), 32'd3);
    check("discarded_dirty_data", 32'(rd), 32'h49);

    repeat (2) @(posedge CLK);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data-cache controller between the 8-bit CPU's load/store path and the word-organised data memory.
- Owns the tag/valid/dirty arrays and the data array. Sequences miss handling (write-back, then fetch, then update) and stalls the CPU through BUSYWAIT so the single-cycle datapath simply freezes PC and register writes.
- Instantiated inside cpu next to reg_file/alu; memory side connects to data_memory.

Parameters:
INDEX_BITS, 3, log2 of block count (default 8 blocks of 4 bytes); TAG_BITS = 6 - INDEX_BITS
OFFSET_BITS, 2, byte offset within a 32-bit block; fixed, not to be overridden

Ports:
CLK  in  1  clock, all state updates on posedge
RESET  in  1  synchronous, active-high
READ  in  1  CPU load request, held until BUSYWAIT low
WRITE  in  1  CPU store request, held until BUSYWAIT low
ADDRESS  in  8  byte address {tag, index, offset}
WRITEDATA  in  8  store data
READDATA  out  8  load data, valid while READ high and BUSYWAIT low
BUSYWAIT  out  1  CPU stall
MEM_READ  out  1  block fetch request
MEM_WRITE  out  1  block write-back request
MEM_ADDRESS  out  6  block address {tag, index}
MEM_WRITEDATA  out  32  write-back block
MEM_READDATA  in  32  fetched block
MEM_BUSYWAIT  in  1  memory busy; memory raises it combinationally with MEM_READ/MEM_WRITE, drops it the cycle data is done

Behaviour:
- Reset (sync, posedge with RESET=1): state IDLE; all valid and dirty bits 0; MEM_READ=MEM_WRITE=0; BUSYWAIT=0 when no request. Data/tag arrays need not clear.
- Reset mid-miss aborts the transaction. MEM_READ/MEM_WRITE drop after that edge, and dirty data being written back is discarded.
- Request: req = READ | WRITE. READ and WRITE both high is illegal; the controller treats it as WRITE.
- hit = valid[index] & (tag_array[index] == tag), combinational.
- BUSYWAIT = req & !(state==IDLE & hit), combinational. It is 0 whenever req=0.
- Read hit: READDATA = byte[offset] of data_array[index] in the same cycle. Latency 0 cycles, no stall.
- Write hit: at the posedge, WRITEDATA is written into byte[offset] and dirty[index] is set to 1. The CPU sees no stall.
- Misses are handled by a state machine (encoding in package):
  - IDLE: on miss, go to WRITEBACK if valid & dirty, else FETCH.
  - WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={tag_array[index], index}, MEM_WRITEDATA=data_array[index]. At a posedge with MEM_BUSYWAIT=0, go to FETCH.
  - FETCH: MEM_READ=1, MEM_ADDRESS={ADDRESS tag, index}. At a posedge with MEM_BUSYWAIT=0, go to UPDATE.
  - UPDATE: at the posedge, data_array[index] takes MEM_READDATA, tag_array[index] takes the new tag, valid=1, dirty=0. Then go to IDLE.
  - IDLE re-evaluates, finds a hit, and BUSYWAIT drops. A write miss then performs its write-hit update at the following posedge.
- Minimum miss latency with a 1-cycle memory: clean miss 3 cycles of BUSYWAIT; dirty miss 4 cycles.
- MEM_READ and MEM_WRITE are never high simultaneously. Outside their states both are 0.
- ADDRESS, WRITEDATA, READ and WRITE must stay stable while BUSYWAIT=1. The controller latches nothing from the CPU.
- Index wrap-around: none. Each index is an independent block; aliasing addresses evict by tag.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, WRITEBACK, FETCH, UPDATE);
  - constants OFFSET_BITS=2 and MEM_ADDR_W=6;
  - helper functions splitting ADDRESS into tag/index/offset.
- One sub-module, dcache_array: tag/valid/dirty/data storage with a byte-write port and a block-fill port. dcache_controller keeps the state machine and handshake logic.

Test Plan:
- Reset, then READ ADDRESS=0x04 -> clean miss: BUSYWAIT high 3 cycles, MEM_READ with MEM_ADDRESS=0x01, no MEM_WRITE; READDATA = byte 0 of MEM_READDATA 0xDDCCBBAA, i.e. 0xAA.
- WRITE 0x05 data 0x5A after the line above is resident -> no stall. A following READ 0x05 returns 0x5A and dirty[1]=1.
- READ 0x25 (same index 1, tag 1) -> MEM_WRITE with MEM_ADDRESS=0x01 and block 0xDDCC5AAA, then MEM_READ with MEM_ADDRESS=0x09. BUSYWAIT is high 4 cycles with 1-cycle memory.
- Memory holds MEM_BUSYWAIT for 5 cycles during FETCH -> MEM_READ stays high throughout, BUSYWAIT stays high, and the transition happens only after the drop.
- RESET asserted during FETCH -> next cycle MEM_READ=0, state IDLE. A re-read of the same address misses again (valid cleared).
- READ and WRITE both high on a hit -> treated as a store; array updated, no stall.
